// File: rtl/pong_vga_pkg.sv
// pong_vga_pkg: shared 640x480@60 timing constants, colour constants,
// pixel-source encoding and object hit-test helper for the Pong renderer.
package pong_vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned BORDER_W = 4;

  localparam logic [2:0] COL_BALL   = 3'b111;
  localparam logic [2:0] COL_P1     = 3'b010;
  localparam logic [2:0] COL_P2     = 3'b001;
  localparam logic [2:0] COL_BORDER = 3'b111;
  localparam logic [2:0] COL_BG     = 3'b000;

  typedef enum logic [2:0] {
    SRC_BG,
    SRC_BORDER,
    SRC_P2,
    SRC_P1,
    SRC_BALL
  } pix_src_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;

  // Rectangle hit test; sums are 11 bits wide so objects near 1023 never wrap to 0.
  function automatic logic in_box(input logic [9:0] h, input logic [9:0] v,
                                  input pos_t p, input logic [10:0] w,
                                  input logic [10:0] ht);
    logic [10:0] hx, vx, x0, y0;
    hx = {1'b0, h};
    vx = {1'b0, v};
    x0 = {1'b0, p.x};
    y0 = {1'b0, p.y};
    return (hx >= x0) && (hx < x0 + w) && (vx >= y0) && (vx < y0 + ht);
  endfunction

  function automatic logic [2:0] src_colour(input pix_src_e s);
    case (s)
      SRC_BALL:   return COL_BALL;
      SRC_P1:     return COL_P1;
      SRC_P2:     return COL_P2;
      SRC_BORDER: return COL_BORDER;
      default:    return COL_BG;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: 800x525 pixel/line counters, raw active-low syncs and the
// visible-area flag for 640x480@60.
module vga_timing
  import pong_vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       active
);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);

  // Pixel counter wraps at end of line and advances the line counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Raw syncs and visible-area flag decoded from the current counters.
  always_comb begin
    hs_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  end

endmodule

// File: rtl/pong_vga_render.sv
// pong_vga_render: Pong frame renderer. Latches ball/paddle positions once per
// frame, drives the processor busy handshake and produces registered VGA
// syncs and 3-bit colour. Define PONG_VGA_BORDER_EN to draw a 4-pixel border.
module pong_vga_render
  import pong_vga_pkg::*;
#(
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned PAD_W     = 8,
  parameter int unsigned PAD_H     = 48
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [9:0] bx_in,
  input  logic [9:0] by_in,
  input  logic [9:0] p1x_in,
  input  logic [9:0] p1y_in,
  input  logic [9:0] p2x_in,
  input  logic [9:0] p2y_in,
  output logic       busy_out,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [2:0] vga_rgb
);

  localparam logic [10:0] BALL_E = 11'(BALL_SIZE);
  localparam logic [10:0] PAD_WE = 11'(PAD_W);
  localparam logic [10:0] PAD_HE = 11'(PAD_H);
  localparam logic [9:0]  BW_LO  = 10'(BORDER_W);
  localparam logic [9:0]  BW_HR  = 10'(H_ACTIVE - BORDER_W);
  localparam logic [9:0]  BW_VB  = 10'(V_ACTIVE - BORDER_W);

  logic [9:0] h_cnt, v_cnt;
  logic       hs_raw, vs_raw, active;
  logic       frame_end, border_en, border_hit;
  pos_t       ball_s, pad1_s, pad2_s;
  pix_src_e   src;

  vga_timing u_timing (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .hs_raw (hs_raw),
    .vs_raw (vs_raw),
    .active (active)
  );

  assign frame_end = (h_cnt == 10'(H_TOTAL - 1)) && (v_cnt == 10'(V_TOTAL - 1));

`ifdef PONG_VGA_BORDER_EN
  assign border_en = 1'b1;
`else
  assign border_en = 1'b0;
`endif

  // Positions are sampled only at the last pixel of the frame so a whole frame renders from one snapshot.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ball_s <= '0;
      pad1_s <= '0;
      pad2_s <= '0;
    end else if (frame_end) begin
      ball_s.x <= bx_in;
      ball_s.y <= by_in;
      pad1_s.x <= p1x_in;
      pad1_s.y <= p1y_in;
      pad2_s.x <= p2x_in;
      pad2_s.y <= p2y_in;
    end
  end

  // Select the highest-priority object covering the current pixel.
  always_comb begin
    border_hit = border_en &&
                 ((h_cnt < BW_LO) || (h_cnt >= BW_HR) || (v_cnt < BW_LO) || (v_cnt >= BW_VB));
    src = SRC_BG;
    if (active) begin
      if (in_box(h_cnt, v_cnt, ball_s, BALL_E, BALL_E))
        src = SRC_BALL;
      else if (in_box(h_cnt, v_cnt, pad1_s, PAD_WE, PAD_HE))
        src = SRC_P1;
      else if (in_box(h_cnt, v_cnt, pad2_s, PAD_WE, PAD_HE))
        src = SRC_P2;
      else if (border_hit)
        src = SRC_BORDER;
    end
  end

  // Output stage: one-cycle registered syncs, colour and busy handshake.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      vga_hs   <= 1'b1;
      vga_vs   <= 1'b1;
      vga_rgb  <= '0;
      busy_out <= 1'b1;
    end else begin
      vga_hs   <= hs_raw;
      vga_vs   <= vs_raw;
      vga_rgb  <= src_colour(src);
      busy_out <= (v_cnt < 10'(V_ACTIVE)) || (v_cnt == 10'(V_TOTAL - 1));
    end
  end

endmodule

// File: tb/tb_pong_vga_render.sv
// tb_pong_vga_render: self-checking bench for pong_vga_render using a
// frame-position reference model and randomized object positions.
module tb_pong_vga_render;

  localparam int FRAME = 800 * 525;
`ifdef PONG_VGA_BORDER_EN
  localparam bit BORDER_ON = 1'b1;
`else
  localparam bit BORDER_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [9:0] bx, by, p1x, p1y, p2x, p2y;
  logic       busy, hs, vs;
  logic [2:0] rgb;

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release and the positions latched for the current frame.
  int edges;
  int sbx, sby, s1x, s1y, s2x, s2y;

  pong_vga_render #(.BALL_SIZE(8), .PAD_W(8), .PAD_H(48)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bx_in         (bx),
    .by_in         (by),
    .p1x_in        (p1x),
    .p1y_in        (p1y),
    .p2x_in        (p2x),
    .p2y_in        (p2y),
    .busy_out      (busy),
    .vga_hs        (hs),
    .vga_vs        (vs),
    .vga_rgb       (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Position p = edges counts scan positions; the frame snapshot is taken when leaving the last one.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges <= 0;
      sbx <= 0; sby <= 0; s1x <= 0; s1y <= 0; s2x <= 0; s2y <= 0;
    end else begin
      if (edges % FRAME == FRAME - 1) begin
        sbx <= int'(bx); sby <= int'(by);
        s1x <= int'(p1x); s1y <= int'(p1y);
        s2x <= int'(p2x); s2y <= int'(p2y);
      end
      edges <= edges + 1;
    end
  end

  // Outputs seen at a negedge describe the scan position one before the edge count.
  function automatic int pos_h();
    return ((edges - 1) % FRAME) % 800;
  endfunction

  function automatic int pos_v();
    return ((edges - 1) % FRAME) / 800;
  endfunction

  function automatic bit in_obj(int h, int v, int x, int y, int w, int ht);
    return (h >= x) && (h < x + w) && (v >= y) && (v < y + ht);
  endfunction

  function automatic logic [2:0] ref_rgb(int h, int v);
    if (h >= 640 || v >= 480) return 3'b000;
    if (in_obj(h, v, sbx, sby, 8, 8))  return 3'b111;
    if (in_obj(h, v, s1x, s1y, 8, 48)) return 3'b010;
    if (in_obj(h, v, s2x, s2y, 8, 48)) return 3'b001;
    if (BORDER_ON && (h < 4 || h >= 636 || v < 4 || v >= 476)) return 3'b111;
    return 3'b000;
  endfunction

  function automatic logic ref_hs(int h);
    return !(h >= 656 && h < 752);
  endfunction

  function automatic logic ref_vs(int v);
    return !(v >= 490 && v < 492);
  endfunction

  function automatic logic ref_busy(int v);
    return (v < 480) || (v == 524);
  endfunction

  function automatic logic [9:0] rnd_coord(int visible);
    int unsigned r;
    if ($urandom_range(0, 3) == 0) r = $urandom_range(0, 1023);
    else r = $urandom_range(0, visible - 1);
    return 10'(r);
  endfunction

  task automatic set_pos(input int b_x, input int b_y, input int a_x, input int a_y,
                         input int c_x, input int c_y);
    bx = 10'(b_x); by = 10'(b_y);
    p1x = 10'(a_x); p1y = 10'(a_y);
    p2x = 10'(c_x); p2y = 10'(c_y);
  endtask

  task automatic wait_pos(input int h, input int v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(edges >= 1 && pos_h() == h && pos_v() == v) && n < FRAME + 10);
    if (n >= FRAME + 10) begin
      checks++;
      errors++;
      $display("FAIL wait_pos: (%0d,%0d) not reached after %0d cycles, required fewer than %0d",
               h, v, n, FRAME + 10);
    end
  endtask

  task automatic sample_row(input int h0, input int v0, input int n,
                            output int white, output int green, output int other);
    white = 0; green = 0; other = 0;
    wait_pos(h0, v0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      case (rgb)
        3'b111:  white++;
        3'b010:  green++;
        default: other++;
      endcase
    end
  endtask

  task automatic scan_white(input int v0, output int first, output int last, output int cnt);
    first = -1; last = -1; cnt = 0;
    wait_pos(4, v0);
    for (int h = 4; h < 636; h++) begin
      if (h > 4) @(negedge clk);
      if (rgb === 3'b111) begin
        if (first < 0) first = h;
        last = h;
        cnt++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_pos(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++; if (hs !== 1'b1) begin errors++; $display("FAIL reset_hs: got %b, want 1", hs); end
    checks++; if (vs !== 1'b1) begin errors++; $display("FAIL reset_vs: got %b, want 1", vs); end
    checks++; if (rgb !== 3'b000) begin errors++; $display("FAIL reset_rgb: got %b, want 000", rgb); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b, want 1", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    // Zeroed snapshot puts the ball at the origin, so pixel (0,0) is white.
    checks++; if (rgb !== 3'b111) begin errors++; $display("FAIL first_pixel_rgb: got %b, want 111", rgb); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_pixel_busy: got %b, want 1", busy); end
    checks++; if (hs !== 1'b1) begin errors++; $display("FAIL first_pixel_hs: got %b, want 1", hs); end
  endtask

  task automatic test_random_frames();
    int rgb_bad, hs_bad, vs_bad, busy_bad, line_bad, frame_bad;
    int line_low, frame_low, hs_total, vs_total, h, v;
    rgb_bad = 0; hs_bad = 0; vs_bad = 0; busy_bad = 0; line_bad = 0; frame_bad = 0;
    line_low = 0; frame_low = 0; hs_total = 0; vs_total = 0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      if (n > 0) @(negedge clk);
      h = pos_h();
      v = pos_v();
      if (rgb !== ref_rgb(h, v)) rgb_bad++;
      if (hs !== ref_hs(h)) hs_bad++;
      if (vs !== ref_vs(v)) vs_bad++;
      if (busy !== ref_busy(v)) busy_bad++;
      if (hs === 1'b0) begin line_low++; hs_total++; end
      if (vs === 1'b0) begin frame_low++; vs_total++; end
      if (h == 799) begin
        if (line_low != 96) line_bad++;
        line_low = 0;
      end
      if (h == 799 && v == 524) begin
        if (frame_low != 1600) frame_bad++;
        frame_low = 0;
      end
      if (h == 400 && $urandom_range(0, 15) == 0)
        set_pos(int'(rnd_coord(640)), int'(rnd_coord(480)), int'(rnd_coord(640)),
                int'(rnd_coord(480)), int'(rnd_coord(640)), int'(rnd_coord(480)));
    end
    checks++; if (rgb_bad != 0) begin errors++; $display("FAIL rand_rgb: %0d pixels differ, want 0", rgb_bad); end
    checks++; if (hs_bad != 0) begin errors++; $display("FAIL rand_hs: %0d cycles differ, want 0", hs_bad); end
    checks++; if (vs_bad != 0) begin errors++; $display("FAIL rand_vs: %0d cycles differ, want 0", vs_bad); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL rand_busy: %0d cycles differ, want 0", busy_bad); end
    checks++; if (line_bad != 0) begin errors++; $display("FAIL hs_per_line: %0d lines without 96 low cycles, want 0", line_bad); end
    checks++; if (frame_bad != 0) begin errors++; $display("FAIL vs_per_frame: %0d frames without 1600 low cycles, want 0", frame_bad); end
    checks++; if (hs_total != 2 * 525 * 96) begin errors++; $display("FAIL hs_total: got %0d, want %0d", hs_total, 2 * 525 * 96); end
    checks++; if (vs_total != 3200) begin errors++; $display("FAIL vs_total: got %0d, want 3200", vs_total); end
  endtask

  task automatic test_busy_window();
    int n;
    wait_pos(799, 479);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_before: got %b, want 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b, want 0", busy); end
    n = 1;
    while (n < 40000) begin
      @(negedge clk);
      if (busy !== 1'b0) break;
      n++;
    end
    checks++; if (n != 35200) begin errors++; $display("FAIL busy_low_len: got %0d, want 35200", n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b, want 1", busy); end
  endtask

  task automatic test_deferred_update();
    int first, last, cnt;
    set_pos(100, 300, 600, 0, 600, 100);
    wait_pos(0, 200);
    bx = 10'd300;
    scan_white(300, first, last, cnt);
    checks++; if (first != 100 || last != 107) begin errors++; $display("FAIL defer_same_frame: span %0d..%0d, want 100..107", first, last); end
    checks++; if (cnt != 8) begin errors++; $display("FAIL defer_same_count: got %0d, want 8", cnt); end
    scan_white(300, first, last, cnt);
    checks++; if (first != 300 || last != 307) begin errors++; $display("FAIL defer_next_frame: span %0d..%0d, want 300..307", first, last); end
  endtask

  task automatic test_right_edge();
    int w, g, o, edge_white, wrap_white;
    wait_pos(0, 500);
    set_pos(636, 0, 300, 300, 400, 300);
    edge_white = 0;
    wrap_white = 0;
    for (int v = 0; v < 8; v++) begin
      sample_row(636, v, 4, w, g, o);
      edge_white += w;
      sample_row(0, v + 1, 4, w, g, o);
      wrap_white += w;
    end
    checks++; if (edge_white != 32) begin errors++; $display("FAIL right_edge_white: got %0d, want 32", edge_white); end
    checks++; if (wrap_white != (BORDER_ON ? 32 : 0)) begin errors++; $display("FAIL right_edge_wrap: got %0d, want %0d", wrap_white, BORDER_ON ? 32 : 0); end
  endtask

  task automatic test_priority();
    int w, g, o, tw, tg, tot;
    wait_pos(0, 500);
    set_pos(20, 100, 20, 100, 20, 290);
    tw = 0; tg = 0; tot = 0;
    for (int v = 100; v < 148; v++) begin
      sample_row(20, v, 8, w, g, o);
      tw += w; tg += g; tot += o;
    end
    checks++; if (tw != 64) begin errors++; $display("FAIL prio_ball: got %0d white, want 64", tw); end
    checks++; if (tg != 320) begin errors++; $display("FAIL prio_paddle: got %0d green, want 320", tg); end
    checks++; if (tot != 0) begin errors++; $display("FAIL prio_other: got %0d other, want 0", tot); end
  endtask

  task automatic test_reset_midframe();
    int k;
    wait_pos(24, 300);
    checks++; if (rgb !== 3'b001) begin errors++; $display("FAIL pre_reset_rgb: got %b, want 001", rgb); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (hs !== 1'b1) begin errors++; $display("FAIL async_hs: got %b, want 1", hs); end
    checks++; if (vs !== 1'b1) begin errors++; $display("FAIL async_vs: got %b, want 1", vs); end
    checks++; if (rgb !== 3'b000) begin errors++; $display("FAIL async_rgb: got %b, want 000", rgb); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL async_busy: got %b, want 1", busy); end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rgb !== 3'b111) begin errors++; $display("FAIL restart_rgb: got %b, want 111", rgb); end
    k = 0;
    while (hs !== 1'b0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k != 656) begin errors++; $display("FAIL restart_hsync: first low at %0d, want 656", k); end
  endtask

  initial begin
    test_reset();
    test_random_frames();
    test_busy_window();
    test_deferred_update();
    test_right_edge();
    test_priority();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
